dsp_mac_pipe: RTL



---
 rtl/dsp_mac_pipe.sv | 270 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/dsp_mac_pipe.sv
// dsp_mac_pipe: three-stage multiply-add/sub-accumulate with round/shift/saturate.
// Build option: define DSP_MAC_PIPE_SATURATE_EN for saturation and overflow detect.
module dsp_mac_pipe #(
    parameter int A_W = 20,
    parameter int B_W = 18,
    parameter int Z_W = 38,
    parameter int SHIFT_W = 6,
    parameter logic [A_W-1:0] COEFF_0 = '0,
    parameter logic [A_W-1:0] COEFF_1 = '0,
    parameter logic [A_W-1:0] COEFF_2 = A_W'(16),
    parameter logic [A_W-1:0] COEFF_3 = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [A_W-1:0]     a,
    input  logic [B_W-1:0]     b,
    input  logic [SHIFT_W-1:0] acc_fir,
    input  logic               use_coeff,
    input  logic [1:0]         coeff_sel,
    input  logic               accumulate,
    input  logic               subtract,
    input  logic               unsigned_a,
    input  logic               unsigned_b,
    input  logic [SHIFT_W-1:0] shift_right,
    input  logic               round,
    input  logic               saturate,
    output logic               out_valid,
    output logic [Z_W-1:0]     z_out,
    output logic               overflow
);

    localparam int I_W = A_W + B_W + 4;
    localparam int EA_W = I_W - A_W;
    localparam int EB_W = I_W - B_W;

    typedef struct packed {
        logic [SHIFT_W-1:0] acc_fir;
        logic               use_coeff;
        logic [1:0]         coeff_sel;
        logic               accumulate;
        logic               subtract;
        logic               unsigned_a;
        logic               unsigned_b;
        logic [SHIFT_W-1:0] shift_right;
        logic               round;
        logic               saturate;
    } ctl1_t;

    typedef struct packed {
        logic               accumulate;
        logic               subtract;
        logic [SHIFT_W-1:0] shift_right;
        logic               round;
        logic               saturate;
    } ctl2_t;

    typedef struct packed {
        logic [SHIFT_W-1:0] shift_right;
        logic               round;
        logic               saturate;
    } ctl3_t;

    ctl1_t in_ctl;

    assign in_ctl = '{
        acc_fir:     acc_fir,
        use_coeff:   use_coeff,
        coeff_sel:   coeff_sel,
        accumulate:  accumulate,
        subtract:    subtract,
        unsigned_a:  unsigned_a,
        unsigned_b:  unsigned_b,
        shift_right: shift_right,
        round:       round,
        saturate:    saturate
    };

    // ---------------- Stage 1: input capture ----------------
    logic           s1_valid;
    logic [A_W-1:0] s1_a;
    logic [B_W-1:0] s1_b;
    ctl1_t          s1_ctl;

    // S1 valid always follows in_valid so bubbles propagate
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= in_valid;
        end
    end

    // S1 operands and controls load only on accepted samples
    always_ff @(posedge clk) begin
        if (in_valid) begin
            s1_a   <= a;
            s1_b   <= b;
            s1_ctl <= in_ctl;
        end
    end

    // ---------------- Stage 2: multiply and addend shift ----------------
    logic [A_W-1:0] coeff;
    logic [A_W-1:0] mult;
    logic [I_W-1:0] ext_a;
    logic [I_W-1:0] ext_m;
    logic [I_W-1:0] ext_b;
    logic [I_W-1:0] prod;
    logic [I_W-1:0] x0;

    // Extend operands to the internal width and form product and shifted addend
    always_comb begin
        coeff = COEFF_0;
        unique case (s1_ctl.coeff_sel)
            2'd0: coeff = COEFF_0;
            2'd1: coeff = COEFF_1;
            2'd2: coeff = COEFF_2;
            2'd3: coeff = COEFF_3;
        endcase
        mult  = s1_ctl.use_coeff ? coeff : s1_a;
        ext_a = {{EA_W{~s1_ctl.unsigned_a & s1_a[A_W-1]}}, s1_a};
        ext_m = {{EA_W{~s1_ctl.unsigned_a & mult[A_W-1]}}, mult};
        ext_b = {{EB_W{~s1_ctl.unsigned_b & s1_b[B_W-1]}}, s1_b};
        prod  = ext_m * ext_b;
        x0    = ext_a << s1_ctl.acc_fir;
    end

    logic           s2_valid;
    logic [I_W-1:0] s2_p;
    logic [I_W-1:0] s2_x0;
    ctl2_t          s2_ctl;

    // S2 valid pipeline
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
        end
    end

    // S2 data registers
    always_ff @(posedge clk) begin
        if (s1_valid) begin
            s2_p   <= prod;
            s2_x0  <= x0;
            s2_ctl <= '{
                accumulate:  s1_ctl.accumulate,
                subtract:    s1_ctl.subtract,
                shift_right: s1_ctl.shift_right,
                round:       s1_ctl.round,
                saturate:    s1_ctl.saturate
            };
        end
    end

    // ---------------- Stage 3: add/sub and accumulator ----------------
    logic [I_W-1:0] acc;
    logic [I_W-1:0] x;
    logic [I_W-1:0] r;

    // Pick the addend and combine with the product, wrapping at I_W
    always_comb begin
        x = s2_ctl.accumulate ? acc : s2_x0;
        r = s2_ctl.subtract ? (x - s2_p) : (x + s2_p);
    end

    logic           s3_valid;
    logic [I_W-1:0] s3_r;
    ctl3_t          s3_ctl;

    // S3 valid and accumulator; ACC feeds the next S2 sample directly
    always_ff @(posedge clk) begin
        if (reset) begin
            s3_valid <= 1'b0;
            acc      <= '0;
        end else begin
            s3_valid <= s2_valid;
            if (s2_valid) begin
                acc <= r;
            end
        end
    end

    // S3 result register ahead of the shift/round/clamp stage
    always_ff @(posedge clk) begin
        if (s2_valid) begin
            s3_r   <= r;
            s3_ctl <= '{
                shift_right: s2_ctl.shift_right,
                round:       s2_ctl.round,
                saturate:    s2_ctl.saturate
            };
        end
    end

    // ---------------- Output: round, shift, clamp ----------------
    logic               sh_zero;
    logic               sh_big;
    logic signed [I_W:0] rnd;
    logic signed [I_W:0] sum;
    logic signed [I_W:0] y;
    logic [Z_W-1:0]     z_n;
    logic               ovf_n;

    assign sh_zero = (s3_ctl.shift_right == '0);
    assign sh_big  = (int'(s3_ctl.shift_right) >= I_W);

    // One extra bit keeps R plus the rounding term exact before shifting
    always_comb begin
        rnd = '0;
        if (s3_ctl.round && !sh_zero && !sh_big) begin
            rnd = (I_W+1)'(1) << (s3_ctl.shift_right - 1'b1);
        end
        sum = {s3_r[I_W-1], s3_r} + rnd;
        y   = sum;
        unique case (1'b1)
            sh_zero: y = sum;
            sh_big:  y = {(I_W+1){s3_r[I_W-1]}};
            default: y = sum >>> s3_ctl.shift_right;
        endcase
    end

`ifdef DSP_MAC_PIPE_SATURATE_EN
    logic [I_W-Z_W+1:0] y_hi;
    logic               y_fits;

    assign y_hi   = y[I_W:Z_W-1];
    assign y_fits = (&y_hi) | ~(|y_hi);

    // Flag out-of-range results and clamp to the signed bound when asked
    always_comb begin
        ovf_n = ~y_fits;
        z_n   = y[Z_W-1:0];
        if (s3_ctl.saturate && !y_fits) begin
            z_n = y[I_W] ? {1'b1, {(Z_W-1){1'b0}}}
                         : {1'b0, {(Z_W-1){1'b1}}};
        end
    end
`else
    logic [I_W-Z_W:0] y_hi_unused;
    logic             sat_unused;

    assign y_hi_unused = y[I_W:Z_W];
    assign sat_unused  = s3_ctl.saturate;

    // Plain truncation, no overflow reporting
    always_comb begin
        ovf_n = 1'b0;
        z_n   = y[Z_W-1:0];
    end
`endif

    // Output register; z_out and overflow hold across bubbles
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            z_out     <= '0;
            overflow  <= 1'b0;
        end else begin
            out_valid <= s3_valid;
            if (s3_valid) begin
                z_out    <= z_n;
                overflow <= ovf_n;
            end
        end
    end

endmodule
